// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: 2-stage pipelined carry-lookahead adder/subtractor with a
// valid/ready handshake on both sides. Stage 1 conditions the operands and
// registers bit and group propagate/generate. Stage 2 resolves the group
// carries and registers the result.
// Define ADDSUB_FLAGS_EN to build the ovf/zero/neg flag outputs.

// Group propagate/generate for one 4-bit lookahead group.
module cla4_pg (
  input  logic [3:0] i_p,
  input  logic [3:0] i_g,
  output logic       o_gp,
  output logic       o_gg
);
  assign o_gp = &i_p;
  assign o_gg = i_g[3] | (i_p[3] & i_g[2]) | ((&i_p[3:2]) & i_g[1]) |
                ((&i_p[3:1]) & i_g[0]);
endmodule

// In-group carries by 4-bit lookahead expansion, then sum = p ^ carries.
// The top generate bit only matters for the group carry-out, which is
// resolved at group level.
module cla4_sum (
  input  logic [3:0] i_p,
  input  logic [2:0] i_g,
  input  logic       i_c,
  output logic [3:0] o_s
);
  logic [3:0] w_c;
  assign w_c[0] = i_c;
  assign w_c[1] = i_g[0] | (i_p[0] & i_c);
  assign w_c[2] = i_g[1] | (i_p[1] & i_g[0]) | ((&i_p[1:0]) & i_c);
  assign w_c[3] = i_g[2] | (i_p[2] & i_g[1]) | ((&i_p[2:1]) & i_g[0]) |
                  ((&i_p[2:0]) & i_c);
  assign o_s    = i_p ^ w_c;
endmodule

module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero,
  output logic             neg
`endif
);
  localparam int NG = WIDTH / GROUP;

  if (GROUP != 4 || WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_cfg
    $error("cla_pipe_addsub: WIDTH must be a multiple of 4 and >= 4, GROUP must be 4");
  end

  // ---------------- stage 1: operand conditioning + group P/G ----------------
  logic [WIDTH-1:0]       w_beff, w_p, w_g;
  logic [NG-1:0]          w_gp, w_gg;
  logic [NG-1:0][2:0]     w_g3;
  logic                   w_c0;

  assign w_beff = sub ? ~b : b;
  assign w_p    = a ^ w_beff;
  assign w_g    = a & w_beff;
  assign w_c0   = cin ^ sub;

  for (genvar k = 0; k < NG; k++) begin : g_s1
    cla4_pg u_pg (
      .i_p  (w_p[4*k +: 4]),
      .i_g  (w_g[4*k +: 4]),
      .o_gp (w_gp[k]),
      .o_gg (w_gg[k])
    );
    assign w_g3[k] = w_g[4*k +: 3];
  end

  // Stage-1 register. Per-bit g is kept (low 3 bits of each group) because
  // the in-group lookahead in stage 2 needs it alongside p.
  logic [WIDTH-1:0]       r_p;
  logic [NG-1:0][2:0]     r_g;
  logic [NG-1:0]          r_gp, r_gg;
  logic                   r_c0;

  // Handshake: r_vld_pipe[1] = stage-1 full, r_vld_pipe[2] = output full.
  logic [2:1]             r_vld_pipe;
  logic                   w_s1_load, w_s2_load;

  assign w_s2_load = r_vld_pipe[1] && (!r_vld_pipe[2] || out_ready);
  assign in_ready  = !r_vld_pipe[1] || w_s2_load;
  assign w_s1_load = in_valid && in_ready;
  assign out_valid = r_vld_pipe[2];

  // Stage-1 data capture on accept; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_s1_load) begin
      r_p  <= w_p;
      r_g  <= w_g3;
      r_gp <= w_gp;
      r_gg <= w_gg;
      r_c0 <= w_c0;
    end
  end

  // ---------------- stage 2: carry resolution + sum ----------------
  logic [NG:0]            w_gc;
  logic [WIDTH-1:0]       w_sum;

  assign w_gc[0] = r_c0;
  for (genvar k = 0; k < NG; k++) begin : g_s2
    assign w_gc[k+1] = r_gg[k] | (r_gp[k] & w_gc[k]);
    cla4_sum u_sum (
      .i_p (r_p[4*k +: 4]),
      .i_g (r_g[k]),
      .i_c (w_gc[k]),
      .o_s (w_sum[4*k +: 4])
    );
  end

  logic [WIDTH-1:0]       r_sum;
  logic                   r_cout;
  assign sum  = r_sum;
  assign cout = r_cout;

  // Valid pipeline and output register; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
    end else begin
      if (w_s1_load)      r_vld_pipe[1] <= 1'b1;
      else if (w_s2_load) r_vld_pipe[1] <= 1'b0;

      if (w_s2_load) begin
        r_vld_pipe[2] <= 1'b1;
        r_sum         <= w_sum;
        r_cout        <= w_gc[NG];
      end else if (out_ready) begin
        r_vld_pipe[2] <= 1'b0;
      end
    end
  end

`ifdef ADDSUB_FLAGS_EN
  logic r_a_msb, r_b_msb;
  logic r_ovf, r_zero, r_neg;
  logic w_ovf;

  assign w_ovf = (r_a_msb == r_b_msb) && (w_sum[WIDTH-1] != r_a_msb);
  assign ovf   = r_ovf;
  assign zero  = r_zero;
  assign neg   = r_neg;

  // Sign bits of the conditioned operands travel with stage 1 for overflow.
  always_ff @(posedge clk) begin
    if (w_s1_load) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= w_beff[WIDTH-1];
    end
  end

  // Flags are registered alongside the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_s2_load) begin
      r_ovf  <= w_ovf;
      r_zero <= (w_sum == '0);
      r_neg  <= w_sum[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub (WIDTH=32). Flags are checked when
// ADDSUB_FLAGS_EN is defined.
module tb_cla_pipe_addsub;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_sub, in_cin;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDSUB_FLAGS_EN
  logic         ovf, zero, neg;
`endif

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (in_a),
    .b         (in_b),
    .sub       (in_sub),
    .cin       (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDSUB_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] sum;
    logic         cout, ovf, zero, neg;
  } exp_t;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic c);
    exp_t e;
    logic [W:0]   u;
    logic [W+1:0] sx, sy, r;
    sx = {{2{x[W-1]}}, x};
    sy = {{2{y[W-1]}}, y};
    if (!s) begin
      u      = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      e.cout = u[W];
      r      = sx + sy + (W+2)'(c);
    end else begin
      e.cout = ({1'b0, x} >= ({1'b0, y} + (W+1)'(c)));  // 1 = no borrow
      r      = sx - sy - (W+2)'(c);
    end
    e.sum  = r[W-1:0];
    e.ovf  = (r != {{2{r[W-1]}}, r[W-1:0]});
    e.zero = (e.sum == '0);
    e.neg  = e.sum[W-1];
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  exp_t sbq[$];
  int   out_cyc[$];
  int   cyc = 0;
  int   n_acc = 0, n_out = 0;
  logic p_hold = 1'b0;
  logic [W-1:0] p_sum;
  logic p_cout;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    // A stalled result must hold stable across the following edge.
    if (p_hold && !rst) begin
      chk("stall_hold_valid", W'(out_valid), W'(1));
      chk("stall_hold_sum", sum, p_sum);
      chk("stall_hold_cout", W'(cout), W'(p_cout));
    end
    p_hold = out_valid && !out_ready && !rst;
    p_sum  = sum;
    p_cout = cout;

    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (sbq.size() == 0) begin
          chk("unexpected_output", W'(1), W'(0));
        end else begin
          e = sbq.pop_front();
          chk("sb_sum", sum, e.sum);
          chk("sb_cout", W'(cout), W'(e.cout));
`ifdef ADDSUB_FLAGS_EN
          chk("sb_ovf", W'(ovf), W'(e.ovf));
          chk("sb_zero", W'(zero), W'(e.zero));
          chk("sb_neg", W'(neg), W'(e.neg));
`endif
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back(model(in_a, in_b, in_sub, in_cin));
        n_acc++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op and wait (bounded) for it to be accepted.
  task automatic push_op(input logic [W-1:0] pa, input logic [W-1:0] pb,
                         input logic ps, input logic pc, output int waits);
    waits    = 0;
    in_a     = pa;
    in_b     = pb;
    in_sub   = ps;
    in_cin   = pc;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 50) begin
        chk("push_timeout", W'(0), W'(1));
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [95:0]  t;
    logic [W-1:0] r;
    t = {$urandom(), $urandom(), $urandom()};
    r = t[W-1:0];
    case ($urandom_range(0, 9))
      0: r = '0;
      1: r = '1;
      2: r = {1'b1, {(W-1){1'b0}}};
      3: r = {1'b0, {(W-1){1'b1}}};
      default: ;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [31:0] a, b;
    logic        s, c;
    logic [31:0] sum;
    logic        cout, ovf, zero, neg;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, base_acc, base_out;
    exp_t e0;

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b1, 32'h21436588, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_sum", sum, W'(0));
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
`ifdef ADDSUB_FLAGS_EN
    chk("rst_flags", W'({ovf, zero, neg}), W'(0));
`endif
    tick();

    // Table vectors: one op at a time, exact 2-cycle latency.
    foreach (tbl[i]) begin
      push_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, w);
      @(negedge clk);
      chk("tbl_lat_early", W'(out_valid), W'(0));
      @(negedge clk);
      chk("tbl_lat_valid", W'(out_valid), W'(1));
      chk("tbl_sum", sum, tbl[i].sum);
      chk("tbl_cout", W'(cout), W'(tbl[i].cout));
`ifdef ADDSUB_FLAGS_EN
      chk("tbl_ovf", W'(ovf), W'(tbl[i].ovf));
      chk("tbl_zero", W'(zero), W'(tbl[i].zero));
      chk("tbl_neg", W'(neg), W'(tbl[i].neg));
`endif
      tick();
    end

    // Back-to-back stream of 8 ops: no stalls, 8 results on consecutive cycles.
    repeat (2) tick();
    out_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      push_op(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      chk("stream_in_ready", W'(w), W'(0));
    end
    repeat (4) tick();
    chk("stream_count", W'(out_cyc.size()), W'(8));
    if (out_cyc.size() == 8) chk("stream_consecutive", W'(out_cyc[7] - out_cyc[0]), W'(7));

    // Stall: out_ready low from the first accept, in_valid held.
    out_ready = 1'b0;
    base_acc  = n_acc;
    base_out  = n_out;
    e0 = model(32'h00000010, 32'h00000020, 1'b0, 1'b0);
    push_op(32'h00000010, 32'h00000020, 1'b0, 1'b0, w);
    push_op(32'h00000100, 32'h00000001, 1'b1, 1'b1, w);
    in_a = 32'hDEADBEEF; in_b = 32'h11111111; in_sub = 1'b0; in_cin = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", W'(in_ready), W'(0));
    end
    chk("stall_accepts", W'(n_acc - base_acc), W'(2));
    chk("stall_sum_op0", sum, e0.sum);
    tick();
    out_ready = 1'b1;
    push_op(32'hDEADBEEF, 32'h11111111, 1'b0, 1'b1, w);
    repeat (5) tick();
    chk("stall_drain_count", W'(n_out - base_out), W'(3));
    chk("stall_drain_empty", W'(sbq.size()), W'(0));

    // Reset with two ops in flight: they must never emerge.
    out_ready = 1'b0;
    push_op(32'h0000AAAA, 32'h00005555, 1'b0, 1'b0, w);
    push_op(32'h00001234, 32'h00000034, 1'b1, 1'b0, w);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_sum", sum, W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    tick();
    base_out  = n_out;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("midrst_no_ghost", W'(n_out - base_out), W'(0));

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = rnd_op();
      in_b      = rnd_op();
      in_sub    = 1'($urandom_range(0, 1));
      in_cin    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("rand_drain_empty", W'(sbq.size()), W'(0));
    chk("rand_out_valid_idle", W'(out_valid), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
